irq_service_sequencer: RTL and testbench

IRQ_SERVICE_SEQUENCER -- requirements
Module: irq_service_sequencer

---
 rtl/irq_service_sequencer_if.sv | 13 +
 rtl/irq_service_sequencer.sv | 95 +++++++++
 tb/tb_irq_service_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_service_sequencer_if.sv
// irq_service_sequencer_if: APB bus between the sequencer (master) and the interrupt controller (slave).
interface irq_service_sequencer_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/irq_service_sequencer.sv
// irq_service_sequencer: round-robin interrupt service -- APB status read, CPU dispatch, APB ack write.
// Optional macro SEQ_TIMEOUT_EN aborts an APB access after TIMEOUT_CYC wait states.
module irq_service_sequencer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    PCLK,
    input  logic                    rstn,
    input  logic [3:0]              INT,
    input  logic [4:0]              IRQ_VECTOR,
    irq_service_sequencer_if.master apb,
    output logic                    irq_req,
    output logic [1:0]              irq_line,
    output logic [4:0]              irq_vec,
    input  logic                    cpu_ack,
    input  logic                    cpu_done,
    output logic [31:0]             irq_status,
    output logic                    busy,
    output logic                    err
);
    typedef enum logic [2:0] {IDLE, ARB, RD_SETUP, RD_ACCESS, DISPATCH, WAIT_DONE, WR_SETUP, WR_ACCESS} state_t;
    state_t state, state_nx;
    logic [1:0] rr_ptr, winner;
    logic access, done, tmo;
    if (TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYC must be at least 1");
    end
    assign access = state == RD_ACCESS || state == WR_ACCESS;
    assign done   = access && apb.PREADY;
`ifdef SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt;
    always_ff @(posedge PCLK or negedge rstn)
        if (!rstn) wait_cnt <= '0;
        else wait_cnt <= (access && !apb.PREADY) ? wait_cnt + 1'b1 : '0;
    assign tmo = access && !apb.PREADY && wait_cnt == CW'(TIMEOUT_CYC - 1);
`else
    assign tmo = 1'b0;
`endif
    // nearest requesting line after rr_ptr wins; rr_ptr itself is searched last
    always_comb begin
        winner = rr_ptr;
        for (int k = 4; k >= 1; k--)
            if (INT[rr_ptr + 2'(k)]) winner = rr_ptr + 2'(k);
    end
    always_ff @(posedge PCLK or negedge rstn)
        if (!rstn) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = |INT ? ARB : IDLE;
            ARB:       state_nx = |INT ? RD_SETUP : IDLE;
            RD_SETUP:  state_nx = RD_ACCESS;
            RD_ACCESS: state_nx = tmo ? IDLE : apb.PREADY ? DISPATCH : RD_ACCESS;
            DISPATCH:  state_nx = cpu_ack ? WAIT_DONE : DISPATCH;
            WAIT_DONE: state_nx = cpu_done ? WR_SETUP : WAIT_DONE;
            WR_SETUP:  state_nx = WR_ACCESS;
            WR_ACCESS: state_nx = (tmo || apb.PREADY) ? IDLE : WR_ACCESS;
            default:   state_nx = IDLE;
        endcase
    end
    always_comb begin
        apb.PSEL    = state inside {RD_SETUP, RD_ACCESS, WR_SETUP, WR_ACCESS};
        apb.PENABLE = access;
        apb.PWRITE  = state == WR_SETUP || state == WR_ACCESS;
        irq_req     = state == DISPATCH;
    end
    // PADDR/PWDATA load on entry to each SETUP so they hold through ACCESS and afterwards
    always_ff @(posedge PCLK or negedge rstn) begin
        if (!rstn) begin
            rr_ptr     <= 2'd3;
            irq_line   <= '0;
            irq_vec    <= '0;
            irq_status <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            apb.PADDR  <= '0;
            apb.PWDATA <= '0;
        end else begin
            busy <= state_nx != IDLE;
            if (state == ARB && |INT) begin
                rr_ptr    <= winner;
                irq_line  <= winner;
                irq_vec   <= IRQ_VECTOR;
                apb.PADDR <= 5'h00;
            end
            if (state == RD_ACCESS && apb.PREADY) irq_status <= apb.PRDATA;
            if (state == WAIT_DONE && cpu_done) begin
                apb.PADDR  <= 5'h10;
                apb.PWDATA <= 32'h1 << irq_vec;
            end
            if ((done && apb.PSLVERR) || tmo) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_irq_service_sequencer.sv
// tb_irq_service_sequencer: randomized services checked against a transaction-level model of the sequencer.
module tb_irq_service_sequencer;
    localparam int TMO = 16;
    logic PCLK = 1'b0, rstn = 1'b0;
    logic [3:0] INT = '0;
    logic [4:0] IRQ_VECTOR = '0;
    logic cpu_ack = 1'b0, cpu_done = 1'b0;
    logic irq_req, busy, err;
    logic [1:0] irq_line;
    logic [4:0] irq_vec;
    logic [31:0] irq_status;
    irq_service_sequencer_if apb();
    irq_service_sequencer #(.TIMEOUT_CYC(TMO)) dut (
        .PCLK(PCLK), .rstn(rstn), .INT(INT), .IRQ_VECTOR(IRQ_VECTOR), .apb(apb),
        .irq_req(irq_req), .irq_line(irq_line), .irq_vec(irq_vec), .cpu_ack(cpu_ack),
        .cpu_done(cpu_done), .irq_status(irq_status), .busy(busy), .err(err)
    );
    always #5 PCLK = ~PCLK;
    int n_chk = 0, n_pass = 0;
    int rr_m = 3;
    logic exp_err = 1'b0, exp_wr = 1'b0;
    logic [1:0] exp_line = '0;
    logic [4:0] exp_vec = '0;
    logic [31:0] exp_status = '0, rd_data = '0, last_wdata = '0;
    int rd_wait = 0, wr_wait = 0;
    logic rd_err = 1'b0, wr_err = 1'b0;
    int acc_cnt = 0, busy_cyc = 0, psel_cyc = 0, wr_done = 0, last_rd_acc = 0;
    logic pend = 1'b0, pend_err = 1'b0, pend_wr = 1'b0, pend_tmo = 1'b0;
    logic [4:0] prev_paddr = '0;
    logic [31:0] prev_pwdata = '0;
    logic prev_pwrite = 1'b0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
    endtask
    // model: program the slave and expectations for one service and raise INT
    task automatic arm(input logic [3:0] iv, input logic [4:0] vec, input logic [31:0] st,
                       input int rw, input int ww, input logic re, input logic we);
        int w;
        w = rr_m;
        for (int k = 1; k <= 4; k++)
            if (iv[(rr_m + k) % 4]) begin
                w = (rr_m + k) % 4;
                break;
            end
        rr_m = w;
        exp_line = 2'(w);
        exp_vec = vec;
        exp_status = st;
        exp_wr = 1'b0;
        rd_wait = rw;
        wr_wait = ww;
        rd_data = st;
        rd_err = re;
        wr_err = we;
        busy_cyc = 0;
        INT = iv;
        IRQ_VECTOR = vec;
    endtask
    task automatic service(input logic [3:0] iv, input logic [4:0] vec, input logic [31:0] st,
                           input int rw, input int ww, input logic re, input logic we,
                           input int al, input int dl, input logic stray,
                           output logic [1:0] line, output int lat, output int bsy);
        int n;
        arm(iv, vec, st, rw, ww, re, we);
        lat = 0;
        while (!irq_req && lat < 200) begin
            @(negedge PCLK);
            lat++;
        end
        chk("irq_req_seen", 32'(irq_req), 1);
        line = irq_line;
        INT = 4'($urandom);
        IRQ_VECTOR = 5'($urandom);
        if (stray) cpu_done = 1'b1;
        repeat (al) @(negedge PCLK);
        cpu_done = 1'b0;
        cpu_ack = 1'b1;
        @(negedge PCLK);
        cpu_ack = 1'b0;
        INT = '0;
        chk("irq_req_drop", 32'(irq_req), 0);
        repeat (dl) @(negedge PCLK);
        cpu_done = 1'b1;
        exp_wr = 1'b1;
        @(negedge PCLK);
        cpu_done = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        chk("busy_release", 32'(busy), 0);
        @(negedge PCLK);
        bsy = busy_cyc;
    endtask
    // compare process plus APB slave; outputs sampled on the falling edge
    initial begin
        apb.PREADY = 1'b0;
        apb.PRDATA = '0;
        apb.PSLVERR = 1'b0;
        forever begin
            @(negedge PCLK);
            if (!rstn) begin
                acc_cnt = 0;
                pend = 1'b0;
                pend_tmo = 1'b0;
                prev_paddr = '0;
                prev_pwdata = '0;
                prev_pwrite = 1'b0;
                apb.PREADY = 1'b0;
                apb.PSLVERR = 1'b0;
            end else begin
                if (pend) begin
                    exp_err = exp_err | pend_err;
                    if (pend_wr) begin
                        wr_done++;
                        last_wdata = prev_pwdata;
                    end
                end
                if (pend_tmo) exp_err = 1'b1;
                pend = 1'b0;
                pend_tmo = 1'b0;
                chk("err", 32'(err), 32'(exp_err));
                chk("idle_ctl", 32'({apb.PENABLE, apb.PWRITE} & {2{~apb.PSEL}}), 0);
                if (!(apb.PSEL && !apb.PENABLE)) begin
                    chk("paddr_hold", 32'(apb.PADDR), 32'(prev_paddr));
                    chk("pwdata_hold", apb.PWDATA, prev_pwdata);
                end
                if (apb.PSEL && apb.PENABLE) chk("pwrite_hold", 32'(apb.PWRITE), 32'(prev_pwrite));
                if (apb.PSEL) begin
                    chk("pwrite", 32'(apb.PWRITE), 32'(exp_wr));
                    chk("paddr", 32'(apb.PADDR), exp_wr ? 32'h10 : 32'h0);
                    if (exp_wr) chk("pwdata", apb.PWDATA, 32'h1 << exp_vec);
                end
                if (irq_req) begin
                    chk("irq_line", 32'(irq_line), 32'(exp_line));
                    chk("irq_vec", 32'(irq_vec), 32'(exp_vec));
                    chk("irq_status", irq_status, exp_status);
                end
                busy_cyc += int'(busy);
                psel_cyc += int'(apb.PSEL);
                if (apb.PSEL && apb.PENABLE) begin
                    apb.PREADY = acc_cnt >= (exp_wr ? wr_wait : rd_wait);
                    apb.PRDATA = rd_data;
                    apb.PSLVERR = apb.PREADY && (exp_wr ? wr_err : rd_err);
                    acc_cnt++;
                    if (apb.PREADY) begin
                        pend = 1'b1;
                        pend_err = apb.PSLVERR;
                        pend_wr = exp_wr;
                        if (!exp_wr) last_rd_acc = acc_cnt;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (acc_cnt == TMO) pend_tmo = 1'b1;
`endif
                end else begin
                    acc_cnt = 0;
                    apb.PREADY = 1'b0;
                    apb.PSLVERR = 1'b0;
                end
                prev_paddr = apb.PADDR;
                prev_pwdata = apb.PWDATA;
                prev_pwrite = apb.PWRITE;
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
    initial begin
        logic [1:0] ln;
        int lat, bsy, n, p, wr0;
        logic seen;
        @(negedge PCLK);
        chk("rst_psel", 32'(apb.PSEL), 0);
        chk("rst_penable", 32'(apb.PENABLE), 0);
        chk("rst_paddr", 32'(apb.PADDR), 0);
        chk("rst_pwdata", apb.PWDATA, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_irq_req", 32'(irq_req), 0);
        rstn = 1'b1;
        @(negedge PCLK);
        for (int i = 0; i < 5; i++) begin
            service(4'hF, 5'(i + 3), 32'h1000 + 32'(i), 0, 0, 1'b0, 1'b0, 1, 1, 1'b0, ln, lat, bsy);
            chk("rr_seq", 32'(ln), 32'(i % 4));
        end
        service(4'b0010, 5'd7, 32'h80, 0, 0, 1'b0, 1'b0, 1, 1, 1'b0, ln, lat, bsy);
        chk("basic_line", 32'(ln), 1);
        chk("basic_vec", 32'(irq_vec), 7);
        chk("basic_status", irq_status, 32'h80);
        chk("basic_wdata", last_wdata, 32'h80);
        chk("basic_wr_paddr", 32'(apb.PADDR), 32'h10);
        chk("basic_latency", 32'(lat), 4);
        chk("basic_busy_len", 32'(bsy), 9);
        service(4'b0100, 5'd3, 32'hDEAD0001, 3, 0, 1'b0, 1'b0, 1, 1, 1'b0, ln, lat, bsy);
        chk("rdwait_latency", 32'(lat), 7);
        chk("rdwait_access_len", 32'(last_rd_acc), 4);
        chk("rdwait_busy_len", 32'(bsy), 12);
        INT = 4'b0001;
        @(negedge PCLK);
        INT = '0;
        chk("drop_busy_arb", 32'(busy), 1);
        p = psel_cyc;
        @(negedge PCLK);
        chk("drop_busy_idle", 32'(busy), 0);
        repeat (5) @(negedge PCLK);
        chk("drop_no_apb", 32'(psel_cyc), 32'(p));
        for (int i = 0; i < 25; i++) begin
            logic [3:0] iv;
            int rw, ww, al, dl;
            iv = 4'($urandom_range(1, 15));
            rw = $urandom_range(0, 3);
            ww = $urandom_range(0, 3);
            al = $urandom_range(1, 3);
            dl = $urandom_range(1, 3);
            service(iv, 5'($urandom), $urandom, rw, ww, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 5) == 0, al, dl, 1'($urandom), ln, lat, bsy);
            chk("rand_latency", 32'(lat), 32'(4 + rw));
            chk("rand_busy_len", 32'(bsy), 32'(7 + rw + ww + al + dl));
        end
        service(4'b1000, 5'd31, 32'h5, 0, 0, 1'b0, 1'b1, 1, 1, 1'b0, ln, lat, bsy);
        chk("slverr_err", 32'(err), 1);
        chk("slverr_idle", 32'(busy), 0);
        service(4'b0001, 5'd2, 32'h6, 0, 0, 1'b0, 1'b0, 2, 2, 1'b0, ln, lat, bsy);
        chk("slverr_next_line", 32'(ln), 0);
        chk("slverr_sticky", 32'(err), 1);
`ifdef SEQ_TIMEOUT_EN
        arm(4'b0010, 5'd4, 32'h9, 1000, 0, 1'b0, 1'b0);
        n = 0;
        while (!(apb.PSEL && apb.PENABLE) && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        INT = '0;
        n = 0;
        seen = 1'b0;
        while (apb.PSEL && apb.PENABLE && n < 100) begin
            seen = seen | irq_req;
            @(negedge PCLK);
            n++;
        end
        chk("tmo_access_len", 32'(n), TMO);
        chk("tmo_psel", 32'(apb.PSEL), 0);
        chk("tmo_err", 32'(err), 1);
        chk("tmo_busy", 32'(busy), 0);
        repeat (3) begin
            @(negedge PCLK);
            seen = seen | irq_req;
        end
        chk("tmo_no_irq_req", 32'(seen), 0);
`else
        service(4'b0010, 5'd4, 32'h9, 40, 0, 1'b0, 1'b0, 1, 1, 1'b0, ln, lat, bsy);
        chk("nowait_limit_latency", 32'(lat), 44);
`endif
        arm(4'b0100, 5'd9, 32'h55, 0, 6, 1'b0, 1'b0);
        n = 0;
        while (!irq_req && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        cpu_ack = 1'b1;
        @(negedge PCLK);
        cpu_ack = 1'b0;
        INT = '0;
        @(negedge PCLK);
        cpu_done = 1'b1;
        exp_wr = 1'b1;
        @(negedge PCLK);
        cpu_done = 1'b0;
        n = 0;
        while (!(apb.PSEL && apb.PENABLE) && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        chk("wr_access_reached", 32'(apb.PENABLE & apb.PWRITE), 1);
        wr0 = wr_done;
        #2;
        rstn = 1'b0;
        rr_m = 3;
        exp_err = 1'b0;
        #1;
        chk("arst_psel", 32'(apb.PSEL), 0);
        chk("arst_penable", 32'(apb.PENABLE), 0);
        chk("arst_pwrite", 32'(apb.PWRITE), 0);
        chk("arst_paddr", 32'(apb.PADDR), 0);
        chk("arst_pwdata", apb.PWDATA, 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_line", 32'(irq_line), 0);
        chk("arst_vec", 32'(irq_vec), 0);
        chk("arst_status", irq_status, 0);
        @(negedge PCLK);
        @(negedge PCLK);
        rstn = 1'b1;
        p = psel_cyc;
        repeat (20) @(negedge PCLK);
        chk("arst_no_write", 32'(wr_done), 32'(wr0));
        chk("arst_no_apb", 32'(psel_cyc), 32'(p));
        chk("arst_idle", 32'(busy), 0);
        service(4'hF, 5'd1, 32'h77, 0, 0, 1'b0, 1'b0, 1, 1, 1'b0, ln, lat, bsy);
        chk("arst_rr_restart", 32'(ln), 0);
        chk("arst_busy_len", 32'(bsy), 9);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
